npu_mem_arbiter: RTL and testbench



---
 rtl/npu_mem_pkg.sv | 9 +
 rtl/npu_mem_arbiter_if.sv | 45 ++++
 rtl/npu_mem_arbiter_sat_counter.sv | 16 +
 rtl/npu_mem_arbiter.sv | 100 ++++++++++
 tb/tb_npu_mem_arbiter.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/npu_mem_pkg.sv
// npu_mem_pkg: shared state encoding, default widths and constants for the
// CPU/NPU data-memory arbiter.
package npu_mem_pkg;
    typedef enum logic [2:0] {IDLE, CPU_RD, NPU_GRANT, NPU_OWN, NPU_REL} arb_state_t;
    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_CNT_W  = 16;
    localparam logic [31:0] NOP_DATA = 32'h0;
endpackage

// File: rtl/npu_mem_arbiter_if.sv
// npu_mem_arbiter_if: CPU request, NPU job/SRAM and data-SRAM signals of the
// arbiter; slave is the arbiter's view, master the surrounding system's.
interface npu_mem_arbiter_if
    import npu_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) ();
    logic              memread_c;
    logic              memwrite_c;
    logic [31:0]       addr_c;
    logic [DATA_W-1:0] wd_c;
    logic [DATA_W-1:0] R_DATA;
    logic              mem_haz;
    logic              EN_NPU;
    logic [ADDR_W-1:0] matA, matB, matC;
    logic              acquire_npu;
    logic              npu_go;
    logic [ADDR_W-1:0] npu_matA, npu_matB, npu_matC;
    logic              npu_rd, npu_wr;
    logic [ADDR_W-1:0] npu_addr;
    logic [DATA_W-1:0] npu_wd;
    logic [DATA_W-1:0] npu_rdata;
    logic              npu_done;
    logic              mem_cs, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [CNT_W-1:0]  npu_cycles;

    modport slave (
        input  memread_c, memwrite_c, addr_c, wd_c, EN_NPU, matA, matB, matC,
               npu_rd, npu_wr, npu_addr, npu_wd, npu_done, mem_rdata,
        output R_DATA, mem_haz, acquire_npu, npu_go, npu_matA, npu_matB, npu_matC,
               npu_rdata, mem_cs, mem_we, mem_addr, mem_wdata, npu_cycles
    );

    modport master (
        output memread_c, memwrite_c, addr_c, wd_c, EN_NPU, matA, matB, matC,
               npu_rd, npu_wr, npu_addr, npu_wd, npu_done, mem_rdata,
        input  R_DATA, mem_haz, acquire_npu, npu_go, npu_matA, npu_matB, npu_matC,
               npu_rdata, mem_cs, mem_we, mem_addr, mem_wdata, npu_cycles
    );
endinterface

// File: rtl/npu_mem_arbiter_sat_counter.sv
// sat_counter: up-counter with synchronous clear that sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= '0;
        else if (clr) q <= '0;
        else if (en && !(&q)) q <= q + W'(1);
    end
endmodule

// File: rtl/npu_mem_arbiter.sv
// npu_mem_arbiter: grants the single-port data SRAM to the CPU MEM stage or the
// NPU, stalling the CPU while the NPU owns the memory.
module npu_mem_arbiter
    import npu_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input logic              clk,
    input logic              rst,
    npu_mem_arbiter_if.slave bus
);
    localparam logic [DATA_W-1:0] NOP = DATA_W'(NOP_DATA);

    arb_state_t        state_q, state_d;
    logic [DATA_W-1:0] rdata_q, wdata;
    logic [ADDR_W-1:0] cpu_addr, addr;
    logic              cpu_req, cs, we, haz;
    logic              unused_addr;

    assign cpu_addr    = bus.addr_c[ADDR_W-1:0];
    assign unused_addr = ^bus.addr_c[31:ADDR_W];
    assign cpu_req     = bus.memread_c | bus.memwrite_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            rdata_q      <= '0;
            bus.npu_matA <= '0;
            bus.npu_matB <= '0;
            bus.npu_matC <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == CPU_RD) rdata_q <= bus.mem_rdata;
            // bases are captured on entry so they are valid alongside npu_go
            if (state_q == IDLE && state_d == NPU_GRANT) begin
                bus.npu_matA <= bus.matA;
                bus.npu_matB <= bus.matB;
                bus.npu_matC <= bus.matC;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cs      = 1'b0;
        we      = 1'b0;
        addr    = '0;
        wdata   = NOP;
        haz     = 1'b0;
        case (state_q)
            IDLE: begin
                cs      = cpu_req;
                we      = bus.memwrite_c;
                addr    = cpu_addr;
                wdata   = bus.memwrite_c ? bus.wd_c : NOP;
                haz     = bus.memread_c & ~bus.memwrite_c;
                state_d = bus.memwrite_c ? IDLE : bus.memread_c ? CPU_RD : bus.EN_NPU ? NPU_GRANT : IDLE;
            end
            CPU_RD: state_d = IDLE;
            NPU_GRANT: begin
                haz     = cpu_req;
                state_d = NPU_OWN;
            end
            NPU_OWN: begin
                haz     = cpu_req;
                cs      = bus.npu_rd | bus.npu_wr;
                we      = bus.npu_wr;
                addr    = bus.npu_addr;
                wdata   = bus.npu_wr ? bus.npu_wd : NOP;
                state_d = bus.npu_done ? NPU_REL : NPU_OWN;
            end
            NPU_REL: begin
                haz     = cpu_req;
                state_d = bus.EN_NPU ? NPU_REL : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // strobes are forced low while reset is held, independent of CPU inputs
    assign bus.mem_cs      = rst & cs;
    assign bus.mem_we      = rst & we;
    assign bus.mem_haz     = rst & haz;
    assign bus.mem_addr    = addr;
    assign bus.mem_wdata   = wdata;
    assign bus.R_DATA      = (state_q == CPU_RD) ? bus.mem_rdata : rdata_q;
    assign bus.npu_rdata   = bus.mem_rdata;
    assign bus.npu_go      = state_q == NPU_GRANT;
    assign bus.acquire_npu = state_q == NPU_REL;

    sat_counter #(.W(CNT_W)) u_cycles (
        .clk   (clk),
        .rst_n (rst),
        .clr   (state_q == NPU_GRANT),
        .en    (state_q == NPU_OWN),
        .q     (bus.npu_cycles)
    );
endmodule

// File: tb/tb_npu_mem_arbiter.sv
// tb_npu_mem_arbiter: randomized CPU/NPU traffic against a behavioural SRAM
// contents model and the arbiter's cycle rules.
module tb_npu_mem_arbiter;
    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int CW  = 5;
    localparam int SAT = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    npu_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) bus ();
    npu_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [DW-1:0] sram    [1<<AW];
    logic [DW-1:0] ref_mem [1<<AW];
    logic [AW-1:0] written [$];
    logic [DW-1:0] last_rd = '0;
    int checks = 0;
    int errors = 0;

    always @(posedge clk)
        if (bus.mem_cs) begin
            if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;
            else bus.mem_rdata <= sram[bus.mem_addr];
        end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] hi_addr(input logic [AW-1:0] a);
        return ($urandom() & 32'hFFFF_FC00) | 32'(a);
    endfunction

    function automatic logic [AW-1:0] pick();
        return written[$urandom_range(0, written.size() - 1)];
    endfunction

    task automatic clear_inputs();
        bus.memread_c = 0; bus.memwrite_c = 0; bus.addr_c = '0; bus.wd_c = '0;
        bus.EN_NPU = 0; bus.matA = '0; bus.matB = '0; bus.matC = '0;
        bus.npu_rd = 0; bus.npu_wr = 0; bus.npu_addr = '0; bus.npu_wd = '0; bus.npu_done = 0;
    endtask

    task automatic cpu_store(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit also_read);
        bus.memwrite_c = 1; bus.memread_c = also_read; bus.addr_c = hi_addr(a); bus.wd_c = d;
        #1;
        check("st_we", bus.mem_we, 1);
        check("st_cs", bus.mem_cs, 1);
        check("st_addr", bus.mem_addr, a);
        check("st_wdata", bus.mem_wdata, d);
        check("st_haz", bus.mem_haz, 0);
        step();
        ref_mem[a] = d;
        written.push_back(a);
        bus.memwrite_c = 0; bus.memread_c = 0;
    endtask

    task automatic cpu_load(input logic [AW-1:0] a);
        bus.memread_c = 1; bus.addr_c = hi_addr(a);
        #1;
        check("ld_haz1", bus.mem_haz, 1);
        check("ld_cs", bus.mem_cs, 1);
        check("ld_we", bus.mem_we, 0);
        check("ld_addr", bus.mem_addr, a);
        step();
        bus.memread_c = 0;
        #1;
        check("ld_haz0", bus.mem_haz, 0);
        check("ld_rdata", bus.R_DATA, ref_mem[a]);
        last_rd = ref_mem[a];
        step();
    endtask

    task automatic npu_job(input int n, input logic [AW-1:0] a, b, c,
                           input bit cpu_pend, input int hold, input bit cpu_first);
        logic [AW-1:0] pa, la, na;
        logic [DW-1:0] exp_rd, wd;
        bit prev_rd, rd, wr;
        int op;
        pa = pick();
        bus.EN_NPU = 1; bus.matA = a; bus.matB = b; bus.matC = c;
        if (cpu_first) begin
            la = pick();
            bus.memread_c = 1; bus.addr_c = hi_addr(la);
            #1;
            check("pre_haz", bus.mem_haz, 1);
            check("pre_go", bus.npu_go, 0);
            step();
            bus.memread_c = 0;
            #1;
            check("pre_rdata", bus.R_DATA, ref_mem[la]);
            check("pre_go2", bus.npu_go, 0);
            last_rd = ref_mem[la];
            step();
        end
        #1;
        check("idle_go0", bus.npu_go, 0);
        check("idle_cs0", bus.mem_cs, 0);
        check("idle_haz0", bus.mem_haz, 0);
        step();
        bus.npu_done = 1; bus.matA = ~a; bus.matB = ~b; bus.matC = ~c;
        #1;
        check("grant_go", bus.npu_go, 1);
        check("grant_matA", bus.npu_matA, a);
        check("grant_matB", bus.npu_matB, b);
        check("grant_matC", bus.npu_matC, c);
        step();
        prev_rd = 0; exp_rd = '0;
        for (int i = 0; i < n; i++) begin
            op = $urandom_range(0, 2);
            wr = op == 2;
            rd = op == 1 || (wr && $urandom_range(0, 1) == 1);
            na = AW'($urandom); wd = $urandom;
            bus.npu_rd = rd; bus.npu_wr = wr; bus.npu_addr = na; bus.npu_wd = wd;
            bus.npu_done = i == n - 1;
            bus.memread_c = cpu_pend; bus.addr_c = hi_addr(pa);
            #1;
            if (i == 0) check("own_cnt0", bus.npu_cycles, 0);
            if (prev_rd) check("npu_rdata", bus.npu_rdata, exp_rd);
            check("own_haz", bus.mem_haz, cpu_pend);
            check("own_cs", bus.mem_cs, rd | wr);
            check("own_we", bus.mem_we, wr);
            if (rd | wr) check("own_addr", bus.mem_addr, na);
            if (wr) check("own_wdata", bus.mem_wdata, wd);
            check("own_acq", bus.acquire_npu, 0);
            check("own_matA", bus.npu_matA, a);
            step();
            if (wr) begin
                ref_mem[na] = wd;
                written.push_back(na);
            end
            prev_rd = rd && !wr;
            exp_rd = ref_mem[na];
        end
        bus.npu_rd = 0; bus.npu_wr = 0; bus.npu_done = 0;
        for (int h = 0; h <= hold; h++) begin
            bus.EN_NPU = h < hold;
            #1;
            if (h == 0 && prev_rd) check("npu_rdata_last", bus.npu_rdata, exp_rd);
            check("rel_acq", bus.acquire_npu, 1);
            check("rel_haz", bus.mem_haz, cpu_pend);
            check("rel_cs", bus.mem_cs, 0);
            check("rel_cnt", bus.npu_cycles, n > SAT ? SAT : n);
            step();
        end
        #1;
        check("post_acq", bus.acquire_npu, 0);
        check("post_go", bus.npu_go, 0);
        if (cpu_pend) begin
            check("post_haz", bus.mem_haz, 1);
            check("post_cs", bus.mem_cs, 1);
            step();
            bus.memread_c = 0;
            #1;
            check("post_rdata", bus.R_DATA, ref_mem[pa]);
            last_rd = ref_mem[pa];
        end else begin
            check("post_haz0", bus.mem_haz, 0);
        end
        step();
    endtask

    initial begin
        logic [AW-1:0] a1, a2;
        int op;
        clear_inputs();
        #1;
        check("rst_haz", bus.mem_haz, 0);
        check("rst_cs", bus.mem_cs, 0);
        check("rst_we", bus.mem_we, 0);
        check("rst_acq", bus.acquire_npu, 0);
        check("rst_go", bus.npu_go, 0);
        check("rst_rdata", bus.R_DATA, 0);
        check("rst_cnt", bus.npu_cycles, 0);
        check("rst_mat", bus.npu_matA, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1;

        cpu_store(10'd5, 32'hDEADBEEF, 0);
        cpu_load(10'd5);
        for (int k = 0; k < 6; k++) cpu_store(AW'($urandom), $urandom, 0);

        a1 = pick(); a2 = pick();
        bus.memread_c = 1; bus.addr_c = hi_addr(a1);
        #1; check("b2b_haz_a", bus.mem_haz, 1);
        step();
        bus.addr_c = hi_addr(a2);
        #1; check("b2b_haz_b", bus.mem_haz, 0); check("b2b_rd1", bus.R_DATA, ref_mem[a1]);
        step();
        #1; check("b2b_haz_c", bus.mem_haz, 1);
        step();
        bus.memread_c = 0;
        #1; check("b2b_haz_d", bus.mem_haz, 0); check("b2b_rd2", bus.R_DATA, ref_mem[a2]);
        last_rd = ref_mem[a2];
        step();

        for (int k = 0; k < 40; k++) begin
            op = $urandom_range(0, 3);
            if (op == 0) cpu_store(AW'($urandom_range(0, 31)), $urandom, 0);
            else if (op == 1) cpu_load(pick());
            else if (op == 3) cpu_store(AW'($urandom_range(0, 31)), $urandom, 1);
            else begin
                bus.npu_done = 1'($urandom);
                #1;
                check("idle_cs", bus.mem_cs, 0);
                check("idle_haz", bus.mem_haz, 0);
                check("idle_rdata", bus.R_DATA, last_rd);
                check("idle_acq", bus.acquire_npu, 0);
                check("idle_go", bus.npu_go, 0);
                step();
                bus.npu_done = 0;
            end
        end

        npu_job(20, 10'd16, 10'd32, 10'd48, 1, 1, 0);
        npu_job(40, AW'($urandom), AW'($urandom), AW'($urandom), 0, 0, 1);
        npu_job(1, AW'($urandom), AW'($urandom), AW'($urandom), 1, 2, 1);
        for (int k = 0; k < 3; k++)
            npu_job($urandom_range(1, 8), AW'($urandom), AW'($urandom), AW'($urandom),
                    1'($urandom), $urandom_range(0, 2), 1'($urandom));
        for (int k = 0; k < 4; k++) cpu_load(pick());

        bus.EN_NPU = 1; bus.matA = 10'd7; bus.matB = 10'd8; bus.matC = 10'd9;
        step();
        step();
        for (int k = 0; k < 3; k++) begin
            bus.npu_rd = 1; bus.npu_addr = AW'($urandom);
            step();
        end
        bus.npu_rd = 0; bus.npu_wr = 1; bus.npu_addr = AW'($urandom); bus.npu_wd = $urandom;
        bus.memread_c = 1; bus.addr_c = hi_addr(pick());
        #1;
        check("mid_cs", bus.mem_cs, 1);
        check("mid_cnt", bus.npu_cycles, 3);
        rst = 0;
        #1;
        check("arst_cs", bus.mem_cs, 0);
        check("arst_we", bus.mem_we, 0);
        check("arst_haz", bus.mem_haz, 0);
        check("arst_acq", bus.acquire_npu, 0);
        check("arst_go", bus.npu_go, 0);
        check("arst_cnt", bus.npu_cycles, 0);
        check("arst_mat", bus.npu_matA, 0);
        check("arst_rdata", bus.R_DATA, 0);
        last_rd = '0;
        step();
        check("arst_acq2", bus.acquire_npu, 0);
        check("arst_cs2", bus.mem_cs, 0);
        bus.npu_wr = 0; bus.memread_c = 0; bus.EN_NPU = 0; bus.npu_done = 1;
        rst = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("rel_acq0", bus.acquire_npu, 0);
            check("rel_go0", bus.npu_go, 0);
            check("rel_haz0", bus.mem_haz, 0);
            step();
        end
        bus.npu_done = 0;
        cpu_load(pick());
        cpu_load(10'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
